// File: rtl/mux_4_1_rr_arbiter_if.sv
// Request/grant bundle between four requesters and the round-robin arbiter.
// Ports: master drives req/done, slave drives gnt, s1/s0, busy and timeout.
interface mux_4_1_rr_arbiter_if;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic       s1;
    logic       s0;
    logic       busy;
    logic       timeout;

    modport master (
        output req,
        output done,
        input  gnt,
        input  s1,
        input  s0,
        input  busy,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output gnt,
        output s1,
        output s0,
        output busy,
        output timeout
    );
endinterface

// File: rtl/mux_4_1_rr_arbiter.sv
// Round-robin arbiter driving the 4:1 mux select among four requesters.
// Ports: clk, rst (sync, active-high), bus (slave: req/done in, gnt/s1/s0/busy/timeout out).
// Optional grant timeout enabled by defining MUX_ARB_TIMEOUT_EN (limit MAX_HOLD cycles).
module mux_4_1_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input logic                  clk,
    input logic                  rst,
    mux_4_1_rr_arbiter_if.slave  bus
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("MAX_HOLD must be in 2..255");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;
    logic       busy_q, busy_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] last_q, last_d;

    logic [1:0] arb_base;
    logic       win_vld;
    logic [1:0] win_idx;
    logic       rel_norm;
    logic       expired;
    logic       release_c;
    logic       forced;

`ifdef MUX_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    logic [7:0] hold_q, hold_d;
    logic       to_q, to_d;
`endif

    // Scan p+1, p+2, p+3, p: the previous owner is considered last.
    function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic       found;
        logic [1:0] res;
        found = 1'b0;
        res   = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = p + 2'(k);
            if (!found && r[idx]) begin
                found = 1'b1;
                res   = idx;
            end
        end
        return {found, res};
    endfunction

    // In GRANT owner_q == last_q, but owner is the documented base on release.
    assign arb_base           = (state_q == IDLE) ? last_q : owner_q;
    assign {win_vld, win_idx} = pick(bus.req, arb_base);

    assign rel_norm = bus.done | ~bus.req[owner_q];
`ifdef MUX_ARB_TIMEOUT_EN
    assign expired  = (hold_q == HOLD_LAST);
`else
    assign expired  = 1'b0;
`endif
    assign release_c = rel_norm | expired;
    // A timeout that coincides with a normal release is not reported.
    assign forced    = expired & ~rel_norm;

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            busy_q  <= 1'b0;
            owner_q <= 2'd0;
            last_q  <= 2'd3;
`ifdef MUX_ARB_TIMEOUT_EN
            hold_q  <= 8'd0;
            to_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            owner_q <= owner_d;
            last_q  <= last_d;
`ifdef MUX_ARB_TIMEOUT_EN
            hold_q  <= hold_d;
            to_q    <= to_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (win_vld) state_d = GRANT;
            end
            GRANT: begin
                if (release_c && !win_vld) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and bookkeeping.
    always_comb begin
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        owner_d = owner_q;
        last_d  = last_q;
`ifdef MUX_ARB_TIMEOUT_EN
        hold_d  = hold_q;
        to_d    = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (win_vld) begin
                    gnt_d   = 4'b0001 << win_idx;
                    sel_d   = win_idx;
                    busy_d  = 1'b1;
                    owner_d = win_idx;
                    last_d  = win_idx;
`ifdef MUX_ARB_TIMEOUT_EN
                    hold_d  = 8'd0;
`endif
                end
            end
            GRANT: begin
                if (release_c) begin
                    // Hand over directly: no all-zero gnt cycle between owners.
                    if (win_vld) begin
                        gnt_d   = 4'b0001 << win_idx;
                        sel_d   = win_idx;
                        owner_d = win_idx;
                        last_d  = win_idx;
                    end else begin
                        gnt_d   = 4'b0000;
                        busy_d  = 1'b0;
                    end
`ifdef MUX_ARB_TIMEOUT_EN
                    hold_d  = 8'd0;
                    to_d    = forced;
`endif
                end else begin
`ifdef MUX_ARB_TIMEOUT_EN
                    hold_d  = hold_q + 8'd1;
`endif
                end
            end
            default: begin
                gnt_d  = 4'b0000;
                busy_d = 1'b0;
            end
        endcase
    end

    assign bus.gnt  = gnt_q;
    assign bus.s1   = sel_q[1];
    assign bus.s0   = sel_q[0];
    assign bus.busy = busy_q;
`ifdef MUX_ARB_TIMEOUT_EN
    assign bus.timeout = to_q;
`else
    assign bus.timeout = 1'b0;
`endif

    logic unused_forced;
    assign unused_forced = forced;

endmodule

// File: doc/mux_4_1_rr_arbiter.md
# mux_4_1_rr_arbiter

Round-robin arbiter sharing the 4:1 mux datapath among four requesters. Each requester asserts a request, and the arbiter grants exactly one of them at a time. It drives the mux select pair (s1, s0) so the granted requester's input reaches y. The grant is held until the owner signals completion or drops its request, then passes to the next requester in rotation with no idle bubble.

## Interface
- MAX_HOLD, 8: maximum grant length in cycles when the timeout is compiled in; legal range 2..255.
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request per requester; bit n corresponds to mux input in.
- done  input  1  current owner's completion strobe; ignored when no grant is active.
- gnt  output  4  one-hot grant, registered; all zeros when idle.
- s1  output  1  mux select MSB, registered.
- s0  output  1  mux select LSB, registered; {s1,s0} equals the granted index.
- busy  output  1  high while a grant is active.
- timeout  output  1  one-cycle pulse on forced release; tied to 0 when the timeout is not compiled in.

## Operation
- State machine with two states, IDLE and GRANT.
- Internal registers:
  - last: index of the previous owner (2 bits).
  - owner: index of the current owner (2 bits).
  - hold_cnt: 8-bit counter, present only with the timeout macro.
- Reset values: IDLE, gnt=0000, s1=0, s0=0, busy=0, timeout=0, last=3, owner=0, hold_cnt=0. With last=3, the first search starts at index 0.
- Arbitration function:
  - Scan indices (p+1)%4, (p+2)%4, (p+3)%4, p, where p is last in IDLE and owner on release.
  - The first index with a set req wins.
  - The previous owner is therefore eligible only when no other requester is asking.
- IDLE:
  - If req is zero, stay in IDLE with all outputs unchanged; {s1,s0} holds its last value.
  - If req is nonzero, move to GRANT. Set gnt to the one-hot winner, {s1,s0}=winner, busy=1, owner=winner, last=winner, hold_cnt=0.
- GRANT, release condition: release occurs when done=1, or req[owner]=0, or (timeout build only) hold_cnt=MAX_HOLD-1.
- GRANT, no release: gnt, select and busy hold their values; hold_cnt increments.
- GRANT, release:
  - Arbitrate in the same cycle using the current req.
  - If there is a winner, the next cycle shows the new grant directly and the state stays GRANT. There is no all-zero cycle on gnt.
  - If there is no winner, go to IDLE with gnt=0000 and busy=0.
- Forced release: behaves exactly like a normal release and additionally drives timeout=1 for one cycle.
- Simultaneous events:
  - done and timeout in the same cycle: timeout is not pulsed.
  - done while req[owner] stays high: the owner rejoins arbitration with the lowest priority.
- gnt is always one-hot or zero. {s1,s0} never changes while busy is high unless the owner changes.

## Timing
- Latency from req sampled in IDLE to gnt asserted is 1 cycle.
- Latency from a release condition sampled in GRANT to the next owner's gnt is 1 cycle (zero bubble).
- All outputs are registered. gnt, {s1,s0} and busy update on the same edge.
- rst asserted in any state, including mid-grant: the next edge restores all reset values. A pending request is re-arbitrated from index 0 after rst deasserts.
- Maximum grant length:
  - With the timeout: MAX_HOLD cycles.
  - Without the timeout: unbounded.

## Configuration
- Macro: MUX_ARB_TIMEOUT_EN.
- Defined:
  - hold_cnt and the forced-release path are present.
  - No owner keeps the grant for more than MAX_HOLD consecutive cycles.
  - timeout pulses on each forced release.
- Undefined:
  - No counter is built.
  - A grant ends only on done or on the owner dropping req.
  - timeout is a constant 0.

## Test plan
- Reset, then req=0101 -> one cycle later gnt=0001, s1s0=00, busy=1. Pulse done -> next cycle gnt=0100, s1s0=10. Pulse done with req=0000 -> gnt=0000, busy=0.
- req=1111 held, done pulsed every 3rd cycle -> grant order 0,1,2,3,0 with no all-zero gnt cycles. Mux y follows i0..i3 accordingly, with i0=1, i1=0, i2=1, i3=0 giving y=1,0,1,0.
- req=0010 only, owner 1 drops req while req=1000 rises in the same cycle -> next cycle gnt=1000, s1s0=11.
- Grant held to owner 2 with req=0100 and rst pulsed -> next cycle gnt=0000, s1s0=00, busy=0. After rst falls, with req=0100 still set -> gnt=0100 one cycle later.
- MUX_ARB_TIMEOUT_EN defined, MAX_HOLD=4, req=0011, done=0 -> owner 0 is granted for 4 cycles, then timeout=1 for one cycle and gnt=0010. This pattern repeats.
- Same stimulus with the macro undefined -> gnt stays 0001 for 50 cycles and timeout stays 0.
